popcnt_arbiter: RTL and testbench
=================================

POPCNT_ARBITER -- requirements
Module: popcnt_arbiter

Interface
REQ-001 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-003 SHALL have port ena, input, 1, grant enable; low blocks new grants.
REQ-004 SHALL have port req_valid, input, 4, per-requester operand valid; bit i belongs to requester i.
REQ-005 SHALL have port req_data, input, 16, operands; requester i at bits [4i+3:4i].
REQ-006 SHALL have port req_ready, output, 4, one-hot grant; bit i set means requester i's operand is accepted this cycle.
REQ-007 SHALL have port res_valid, output, 1, result-slot occupied.
REQ-008 SHALL have port res_ready, input, 1, downstream accepts the result.
REQ-009 SHALL have port res_id, output, 2, requester index of the held result.
REQ-010 SHALL have port res_count, output, 3, binary ones-count 0..4 of the held operand.
REQ-011 SHALL have port res_onehot, output, 5, one-hot count; bit k set iff res_count==k.

Function
REQ-012 SHALL transfer operand i when req_valid[i] and req_ready[i] are both high at a rising edge.
REQ-013 SHALL assert at most one req_ready bit, and only for a requester whose req_valid is high.
REQ-014 SHALL derive req_ready combinationally from req_valid, ena, the round-robin pointer and the slot state; no dependence on req_data.
REQ-015 SHALL grant only when ena=1 and the slot is free: res_valid=0, or res_valid=1 and res_ready=1 in the same cycle.
REQ-016 SHALL select the winner round-robin: first asserted req_valid searching upward from pointer ptr, modulo 4.
REQ-017 SHALL set ptr to (winner+1) mod 4 after each grant; ptr SHALL hold when no grant occurs.
REQ-018 SHALL load res_id, res_count and res_onehot, and set res_valid, on the edge of the transfer; latency is 1 cycle.
REQ-019 SHALL hold res_id/res_count/res_onehot stable while res_valid=1 and res_ready=0.
REQ-020 SHALL clear res_valid on a drain (res_valid & res_ready) with no simultaneous grant; on drain plus grant the slot reloads with res_valid staying 1.
REQ-021 SHALL, when ena=0, still permit draining of the held result.
REQ-022 SHALL sustain one result per cycle with res_ready held high.
REQ-023 SHALL ignore res_ready while res_valid=0.

Reset
REQ-024 SHALL, on rst=1 at a rising edge, set res_valid=0, res_id=0, res_count=0, res_onehot=5'b00001 and ptr=0, discarding any held result.
REQ-025 SHALL hold req_ready=0 in every cycle where rst=1.

Configuration
REQ-026 SHALL compile per-requester grant statistics only when macro POPCNT_ARB_STATS_EN is defined.
REQ-027 SHALL, with POPCNT_ARB_STATS_EN defined, add ports stat_sel input 2 and stat_count output 8; stat_count is the saturating (stops at 255) grant count of requester stat_sel, combinational read, cleared by rst.
REQ-028 SHALL, without POPCNT_ARB_STATS_EN, omit the stat ports and counters; all other behaviour identical.

Structure
REQ-029 SHALL place in a shared package: NUM_REQ=4, OP_W=4, CNT_W=3, ID_W=2, STAT_W=8 and the result-record typedef (id, count, onehot).
REQ-030 SHALL implement the ones-count in a combinational sub-module popcnt4 (4-bit in, 3-bit binary count plus 5-bit one-hot out), instantiated once and shared by the winner mux.

Verification
REQ-031 SHALL test reset mid-result: res_valid=1 held (res_ready=0), rst pulse -> next cycle res_valid=0, res_onehot=00001, ptr=0.
REQ-032 SHALL test a single request: req_valid=0001, req_data[3:0]=1011, res_ready=1 -> req_ready=0001, next cycle res_valid=1, res_id=0, res_count=3, res_onehot=01000.
REQ-033 SHALL test round-robin: req_valid=1111 constant, res_ready=1 -> grants 0,1,2,3,0 on consecutive cycles, one result per cycle.
REQ-034 SHALL test backpressure: res_ready=0 with req_valid=0110 -> one grant (id 1), then req_ready=0000 and outputs stable; res_ready=1 -> drain plus grant id 2 in the same cycle.
REQ-035 SHALL test ena gating: ena=0, req_valid=1111, result held -> req_ready=0000, result drains on res_ready=1, ptr unchanged.
REQ-036 SHALL test stats with POPCNT_ARB_STATS_EN: 300 grants to requester 3 -> stat_sel=3 gives stat_count=255, stat_sel=0 gives 0.

Source files
------------

// File: rtl/popcnt_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : popcnt_arbiter_pkg
// Description : Shared sizes and the result record for popcnt_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package popcnt_arbiter_pkg;

    localparam int NUM_REQ = 4;
    localparam int OP_W    = 4;
    localparam int CNT_W   = 3;
    localparam int ID_W    = 2;
    localparam int STAT_W  = 8;
    localparam int HOT_W   = OP_W + 1;   // one bit per possible count 0..OP_W

    typedef struct packed {
        logic [ID_W-1:0]  id;
        logic [CNT_W-1:0] count;
        logic [HOT_W-1:0] onehot;
    } result_t;

    // Empty slot: count 0, so the one-hot form has bit 0 set
    localparam result_t c_RESULT_RST = '{id: '0, count: '0, onehot: HOT_W'(1)};

endpackage : popcnt_arbiter_pkg
`default_nettype wire

// File: rtl/popcnt_arbiter_popcnt4.sv
`default_nettype none
// ============================================================================
// Module      : popcnt4
// Description : Combinational ones-count of a 4-bit operand, given both as a
//               binary count and as a one-hot vector (bit k <=> count == k).
// Revision    : 1.0 - initial release
// ============================================================================
module popcnt4
    import popcnt_arbiter_pkg::*;
(
    input  logic [OP_W-1:0]  i_op,
    output logic [CNT_W-1:0] o_count,
    output logic [HOT_W-1:0] o_onehot
);

    logic [CNT_W-1:0] w_sum;

    // Add up the set bits of the operand
    always_comb begin
        w_sum = '0;
        for (int i = 0; i < OP_W; i++) begin
            w_sum = w_sum + CNT_W'(i_op[i]);
        end
    end

    assign o_count  = w_sum;
    assign o_onehot = HOT_W'(1) << w_sum;

endmodule : popcnt4
`default_nettype wire

// File: rtl/popcnt_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : popcnt_arbiter
// Description : Round-robin arbiter over four 4-bit operands feeding a single
//               result slot that holds the winner's id and ones-count.
//               Optional per-requester saturating grant counters are built
//               when POPCNT_ARB_STATS_EN is defined (adds stat_sel/stat_count).
// Revision    : 1.0 - initial release
// ============================================================================
module popcnt_arbiter
    import popcnt_arbiter_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ena,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*OP_W-1:0]  req_data,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [ID_W-1:0]          res_id,
    output logic [CNT_W-1:0]         res_count,
    output logic [HOT_W-1:0]         res_onehot
`ifdef POPCNT_ARB_STATS_EN
    ,
    input  logic [ID_W-1:0]          stat_sel,
    output logic [STAT_W-1:0]        stat_count
`endif
);

    logic [ID_W-1:0]  r_ptr;
    logic             r_valid;
    result_t          r_res;

    logic             w_slot_free;
    logic             w_grant_ok;
    logic             w_found;
    logic [ID_W-1:0]  w_win;
    logic [OP_W-1:0]  w_win_op;
    logic [CNT_W-1:0] w_count;
    logic [HOT_W-1:0] w_onehot;
    logic             w_grant;

    // The slot can take a new operand if it is empty or being drained now
    assign w_slot_free = !r_valid || res_ready;
    assign w_grant_ok  = ena && !rst && w_slot_free;

    // Round-robin search: first valid requester at or above the pointer,
    // wrapping through the 2-bit index arithmetic
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!w_found && req_valid[r_ptr + ID_W'(k)]) begin
                w_found = 1'b1;
                w_win   = r_ptr + ID_W'(k);
            end
        end
    end

    // One-hot grant to the search winner when the slot can accept it
    always_comb begin
        req_ready = '0;
        if (w_grant_ok && w_found) begin
            req_ready[w_win] = 1'b1;
        end
    end

    assign w_grant  = w_grant_ok && w_found;
    assign w_win_op = req_data[w_win*OP_W +: OP_W];

    popcnt4 u_popcnt4 (
        .i_op     (w_win_op),
        .o_count  (w_count),
        .o_onehot (w_onehot)
    );

    // Result slot and pointer: load on grant, otherwise drain or hold
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_res   <= c_RESULT_RST;
            r_ptr   <= '0;
        end else if (w_grant) begin
            r_valid      <= 1'b1;
            r_res.id     <= w_win;
            r_res.count  <= w_count;
            r_res.onehot <= w_onehot;
            r_ptr        <= w_win + ID_W'(1);
        end else if (r_valid && res_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign res_valid  = r_valid;
    assign res_id     = r_res.id;
    assign res_count  = r_res.count;
    assign res_onehot = r_res.onehot;

`ifdef POPCNT_ARB_STATS_EN
    logic [STAT_W-1:0] w_stat [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_stat
        logic [STAT_W-1:0] r_cnt;

        // Count grants to this requester, sticking at the maximum value
        always_ff @(posedge clk) begin
            if (rst) begin
                r_cnt <= '0;
            end else if (req_ready[g] && (r_cnt != '1)) begin
                r_cnt <= r_cnt + STAT_W'(1);
            end
        end

        assign w_stat[g] = r_cnt;
    end

    assign stat_count = w_stat[stat_sel];
`endif

endmodule : popcnt_arbiter
`default_nettype wire

// File: tb/tb_popcnt_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_popcnt_arbiter
// Description : Self-checking bench for popcnt_arbiter: fixed vector table,
//               directed corner sequences and random traffic against a
//               behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_popcnt_arbiter;

    typedef struct {
        bit          rst;
        bit          ena;
        logic [3:0]  rv;
        logic [15:0] data;
        bit          rr;
        logic [3:0]  ex_ready;
        bit          ex_valid;
        logic [1:0]  ex_id;
        logic [2:0]  ex_cnt;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ena = 1'b0;
    logic [3:0]  req_valid = '0;
    logic [15:0] req_data = '0;
    logic [3:0]  req_ready;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [1:0]  res_id;
    logic [2:0]  res_count;
    logic [4:0]  res_onehot;
`ifdef POPCNT_ARB_STATS_EN
    logic [1:0]  stat_sel = '0;
    logic [7:0]  stat_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model of the arbiter state
    int m_ptr   = 0;
    bit m_valid = 0;
    int m_id    = 0;
    int m_cnt   = 0;

    always #5 clk = ~clk;

    popcnt_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .ena        (ena),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_id     (res_id),
        .res_count  (res_count),
        .res_onehot (res_onehot)
`ifdef POPCNT_ARB_STATS_EN
        ,
        .stat_sel   (stat_sel),
        .stat_count (stat_count)
`endif
    );

    task automatic chk(input string name, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic logic [3:0] model_ready(input bit r, input bit e,
                                               input logic [3:0] rv, input bit rr);
        if (r || !e || (m_valid && !rr)) return 4'b0000;
        for (int k = 0; k < 4; k++) begin
            int idx = (m_ptr + k) % 4;
            if (rv[idx]) return 4'(1 << idx);
        end
        return 4'b0000;
    endfunction

    // Drive one cycle, check req_ready mid-cycle and the slot after the edge.
    // use_model selects model expectations instead of the vector's own.
    task automatic apply(input vec_t v, input bit use_model, input string tag);
        logic [3:0] mr;
        int         win;
        rst       = v.rst;
        ena       = v.ena;
        req_valid = v.rv;
        req_data  = v.data;
        res_ready = v.rr;
        mr = model_ready(v.rst, v.ena, v.rv, v.rr);
        #3;
        chk({tag, ".req_ready"}, int'(req_ready), use_model ? int'(mr) : int'(v.ex_ready));
        @(posedge clk);
        // model update at the edge
        if (v.rst) begin
            m_valid = 0; m_id = 0; m_cnt = 0; m_ptr = 0;
        end else if (mr != 4'b0000) begin
            win = 0;
            for (int i = 0; i < 4; i++) if (mr[i]) win = i;
            m_valid = 1;
            m_id    = win;
            m_cnt   = $countones(v.data[win*4 +: 4]);
            m_ptr   = (win + 1) % 4;
        end else if (m_valid && v.rr) begin
            m_valid = 0;
        end
        #1;
        if (use_model) begin
            chk({tag, ".res_valid"},  int'(res_valid),  int'(m_valid));
            chk({tag, ".res_id"},     int'(res_id),     m_id);
            chk({tag, ".res_count"},  int'(res_count),  m_cnt);
            chk({tag, ".res_onehot"}, int'(res_onehot), 1 << m_cnt);
        end else begin
            chk({tag, ".res_valid"},  int'(res_valid),  int'(v.ex_valid));
            chk({tag, ".res_id"},     int'(res_id),     int'(v.ex_id));
            chk({tag, ".res_count"},  int'(res_count),  int'(v.ex_cnt));
            chk({tag, ".res_onehot"}, int'(res_onehot), 1 << v.ex_cnt);
        end
    endtask

    vec_t tbl [8];
    vec_t seq [11];
    vec_t rv_t;

    initial begin
        // {rst, ena, req_valid, req_data, res_ready, exp_ready, exp_valid, exp_id, exp_cnt}
        tbl[0] = '{1, 1, 4'b1111, 16'h0000, 0, 4'b0000, 0, 0, 0};  // reset state
        tbl[1] = '{0, 1, 4'b0001, 16'h000B, 1, 4'b0001, 1, 0, 3};  // single request
        tbl[2] = '{0, 1, 4'b1111, 16'hF731, 1, 4'b0010, 1, 1, 2};  // round robin
        tbl[3] = '{0, 1, 4'b1111, 16'hF731, 1, 4'b0100, 1, 2, 3};
        tbl[4] = '{0, 1, 4'b1111, 16'hF731, 1, 4'b1000, 1, 3, 4};
        tbl[5] = '{0, 1, 4'b1111, 16'hF731, 1, 4'b0001, 1, 0, 1};
        tbl[6] = '{0, 1, 4'b0000, 16'hF731, 1, 4'b0000, 0, 0, 1};  // drain
        tbl[7] = '{0, 0, 4'b0001, 16'h0000, 0, 4'b0000, 0, 0, 1};  // idle, ena low

        // reset with a result held, then pointer back at 0
        seq[0]  = '{0, 1, 4'b0100, 16'h0600, 0, 4'b0100, 1, 2, 2};
        seq[1]  = '{0, 1, 4'b0000, 16'h0000, 0, 4'b0000, 1, 2, 2};
        seq[2]  = '{1, 1, 4'b1111, 16'hF731, 0, 4'b0000, 0, 0, 0};
        seq[3]  = '{0, 1, 4'b1111, 16'hF731, 1, 4'b0001, 1, 0, 1};
        // backpressure: one grant, hold, then drain plus grant
        seq[4]  = '{0, 1, 4'b0000, 16'hF731, 1, 4'b0000, 0, 0, 1};
        seq[5]  = '{0, 1, 4'b0110, 16'hF731, 0, 4'b0010, 1, 1, 2};
        seq[6]  = '{0, 1, 4'b0110, 16'hF731, 0, 4'b0000, 1, 1, 2};
        seq[7]  = '{0, 1, 4'b0110, 16'hF731, 1, 4'b0100, 1, 2, 3};
        // ena gating: no grants, drain still works, pointer untouched
        seq[8]  = '{0, 0, 4'b1111, 16'hF731, 0, 4'b0000, 1, 2, 3};
        seq[9]  = '{0, 0, 4'b1111, 16'hF731, 1, 4'b0000, 0, 2, 3};
        seq[10] = '{0, 1, 4'b1111, 16'hF731, 1, 4'b1000, 1, 3, 4};

        @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) apply(tbl[i], 0, $sformatf("tbl%0d", i));
        for (int i = 0; i < 11; i++) apply(seq[i], 0, $sformatf("seq%0d", i));

        // random traffic against the model
        for (int i = 0; i < 400; i++) begin
            rv_t.rst  = ($urandom % 32) == 0;
            rv_t.ena  = ($urandom % 8) != 0;
            rv_t.rv   = 4'($urandom);
            rv_t.data = 16'($urandom);
            rv_t.rr   = ($urandom % 4) != 0;
            rv_t.ex_ready = '0; rv_t.ex_valid = 0; rv_t.ex_id = '0; rv_t.ex_cnt = '0;
            apply(rv_t, 1, $sformatf("rnd%0d", i));
        end

`ifdef POPCNT_ARB_STATS_EN
        rv_t = '{1, 1, 4'b0000, 16'h0000, 0, 4'b0000, 0, 0, 0};
        apply(rv_t, 1, "st_rst");
        for (int i = 0; i < 300; i++) begin
            rv_t = '{0, 1, 4'b1000, 16'h5000, 1, 4'b0000, 0, 0, 0};
            apply(rv_t, 1, $sformatf("st%0d", i));
        end
        req_valid = '0;
        stat_sel  = 2'd3;
        #1;
        chk("stat3", int'(stat_count), 255);
        stat_sel  = 2'd0;
        #1;
        chk("stat0", int'(stat_count), 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_popcnt_arbiter
`default_nettype wire
